// File: rtl/synth_pkg.sv
// Shared PS/2 decoder definitions: FSM states, scan-code constants and the note key table.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_AA     = 8'hAA;
  localparam logic [7:0] SC_FA     = 8'hFA;
  localparam logic [7:0] SC_FE     = 8'hFE;
  localparam logic [7:0] SC_EE     = 8'hEE;
  localparam logic [7:0] SC_00     = 8'h00;
  localparam logic [7:0] SC_FF     = 8'hFF;
  localparam logic [7:0] SC_VOL_UP = 8'h79;
  localparam logic [7:0] SC_VOL_DN = 8'h7B;

  localparam int unsigned NOTE_TBL_LEN = 8;

  // Entry i holds the scan code of note index i.
  localparam logic [NOTE_TBL_LEN-1:0][7:0] NOTE_TBL = {
    8'h42, 8'h3B, 8'h33, 8'h34, 8'h2B, 8'h23, 8'h1B, 8'h1C
  };

  // Keyboard status/ack bytes that never start or complete a key event.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_FE) ||
           (b == SC_EE) || (b == SC_00) || (b == SC_FF);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-strobe input and key/note event outputs of the PS/2 key decoder.
interface ps2_key_decoder_if #(
  parameter int unsigned NOTE_CNT = 8
);
  localparam int unsigned IDX_W = (NOTE_CNT > 1) ? $clog2(NOTE_CNT) : 1;

  logic [7:0]       ps2_data_i;
  logic             ps2_data_en_i;
  logic             key_vld_o;
  logic [7:0]       key_code_o;
  logic             key_ext_o;
  logic             key_brk_o;
  logic             note_vld_o;
  logic [IDX_W-1:0] note_idx_o;
  logic             note_on_o;
  logic             vol_up_o;
  logic             vol_dn_o;
  logic             err_o;

  modport master (
    output ps2_data_i, ps2_data_en_i,
    input  key_vld_o, key_code_o, key_ext_o, key_brk_o,
    input  note_vld_o, note_idx_o, note_on_o, vol_up_o, vol_dn_o, err_o
  );

  modport slave (
    input  ps2_data_i, ps2_data_en_i,
    output key_vld_o, key_code_o, key_ext_o, key_brk_o,
    output note_vld_o, note_idx_o, note_on_o, vol_up_o, vol_dn_o, err_o
  );
endinterface

// File: rtl/ps2_note_map.sv
// Combinational scan code -> note index lookup over the first NOTE_CNT table entries.
module ps2_note_map
  import synth_pkg::*;
#(
  parameter int unsigned NOTE_CNT = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [7:0]       code_i,
  output logic             hit_c,
  output logic [IDX_W-1:0] idx_c
);

  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int unsigned i = 0; i < NOTE_TBL_LEN; i++) begin
      if (!hit_c && (i < NOTE_CNT) && (code_i == NOTE_TBL[i])) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: prefix FSM with timeout, key events, held-note tracking and volume pulses.
module ps2_key_decoder
  import synth_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned NOTE_CNT    = 8
) (
  input logic               clk_i,
  input logic               rst_n_i,
  ps2_key_decoder_if.slave  bus
);

  localparam int unsigned IDX_W = (NOTE_CNT > 1) ? $clog2(NOTE_CNT) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  ps2_state_e       state_q, state_d, cur_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic             key_vld_q, key_vld_d;
  logic             note_vld_q, note_vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             on_q, on_d;
  logic             vol_up_q, vol_up_d, vol_dn_q, vol_dn_d;
  logic             err_q, err_d;

  logic             timeout;
  logic             evt, evt_ext, evt_brk;
  logic             map_hit;
  logic [IDX_W-1:0] map_idx;
  logic [7:0]       data;
  logic             strobe;

  assign data   = bus.ps2_data_i;
  assign strobe = bus.ps2_data_en_i;

  ps2_note_map #(
    .NOTE_CNT (NOTE_CNT),
    .IDX_W    (IDX_W)
  ) u_note_map (
    .code_i (data),
    .hit_c  (map_hit),
    .idx_c  (map_idx)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    idx_d      = idx_q;
    on_d       = on_q;
    key_vld_d  = 1'b0;
    note_vld_d = 1'b0;
    vol_up_d   = 1'b0;
    vol_dn_d   = 1'b0;
    err_d      = 1'b0;
    evt        = 1'b0;
    evt_ext    = 1'b0;
    evt_brk    = 1'b0;

    // An expiring prefix is dropped first so a coincident byte decodes from IDLE.
    timeout   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    cur_state = timeout ? IDLE : state_q;
    if (timeout) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end

    if (strobe) begin
      unique case (cur_state)
        IDLE: begin
          if (data == SC_E0)        state_d = EXT;
          else if (data == SC_F0)   state_d = BRK;
          else if (!is_discard(data)) evt = 1'b1;
        end
        EXT: begin
          if (data == SC_F0)        state_d = EXT_BRK;
          else if (data == SC_E0)   err_d = 1'b1;
          else begin
            evt     = 1'b1;
            evt_ext = 1'b1;
            state_d = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if ((data == SC_E0) || (data == SC_F0)) err_d = 1'b1;
          else begin
            evt     = 1'b1;
            evt_brk = 1'b1;
            evt_ext = (cur_state == EXT_BRK);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    cnt_d = (strobe || timeout || (state_q == IDLE)) ? '0 : cnt_q + CNT_W'(1);

    if (evt) begin
      key_vld_d = 1'b1;
      code_d    = data;
      ext_d     = evt_ext;
      brk_d     = evt_brk;
      if (!evt_ext && map_hit) begin
        if (!evt_brk) begin
          // A repeat of the held note is typematic and leaves the note state alone.
          if (!on_q || (map_idx != idx_q)) begin
            idx_d      = map_idx;
            on_d       = 1'b1;
            note_vld_d = 1'b1;
          end
        end else if (map_idx == idx_q) begin
          on_d = 1'b0;
        end
      end
      if (!evt_ext && !evt_brk) begin
        vol_up_d = (data == SC_VOL_UP);
        vol_dn_d = (data == SC_VOL_DN);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      idx_q      <= '0;
      on_q       <= 1'b0;
      key_vld_q  <= 1'b0;
      note_vld_q <= 1'b0;
      vol_up_q   <= 1'b0;
      vol_dn_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      idx_q      <= idx_d;
      on_q       <= on_d;
      key_vld_q  <= key_vld_d;
      note_vld_q <= note_vld_d;
      vol_up_q   <= vol_up_d;
      vol_dn_q   <= vol_dn_d;
      err_q      <= err_d;
    end
  end

  assign bus.key_vld_o  = key_vld_q;
  assign bus.key_code_o = code_q;
  assign bus.key_ext_o  = ext_q;
  assign bus.key_brk_o  = brk_q;
  assign bus.note_vld_o = note_vld_q;
  assign bus.note_idx_o = idx_q;
  assign bus.note_on_o  = on_q;
  assign bus.vol_up_o   = vol_up_q;
  assign bus.vol_dn_o   = vol_dn_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: queue-based prefix model compared every cycle, plus literal spot checks.
module tb_ps2_key_decoder;

  localparam int TO = 50000;
  localparam int NC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder_if #(.NOTE_CNT(NC)) bus ();

  ps2_key_decoder #(.TIMEOUT_CYC(TO), .NOTE_CNT(NC)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: pending prefix bytes and cycles spent waiting on them.
  byte unsigned pending[$];
  int           age;
  logic [7:0]   note_keys [NC] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
  logic         m_kvld, m_ext, m_brk, m_nvld, m_on, m_up, m_dn, m_err;
  logic [7:0]   m_code;
  logic [2:0]   m_idx;

  function automatic bit ignored(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF;
  endfunction

  task automatic model_event(input logic [7:0] b, input bit e, input bit k);
    int hit_idx;
    m_kvld = 1; m_code = b; m_ext = e; m_brk = k;
    hit_idx = -1;
    for (int i = 0; i < NC; i++) if (hit_idx < 0 && note_keys[i] == b) hit_idx = i;
    if (!e && hit_idx >= 0) begin
      if (!k) begin
        if (!m_on || 3'(hit_idx) != m_idx) begin
          m_idx = 3'(hit_idx); m_on = 1; m_nvld = 1;
        end
      end else if (3'(hit_idx) == m_idx) m_on = 0;
    end
    if (!e && !k) begin
      m_up = (b == 8'h79);
      m_dn = (b == 8'h7B);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending.delete(); age = 0;
      m_kvld = 0; m_ext = 0; m_brk = 0; m_nvld = 0; m_on = 0;
      m_up = 0; m_dn = 0; m_err = 0; m_code = 0; m_idx = 0;
    end else begin
      bit had, to;
      logic [7:0] b;
      b = bus.ps2_data_i;
      m_kvld = 0; m_nvld = 0; m_up = 0; m_dn = 0; m_err = 0;
      had = pending.size() != 0;
      to  = had && age == TO - 1;
      if (to) begin pending.delete(); m_err = 1; end
      if (bus.ps2_data_en_i) begin
        if (pending.size() == 0) begin
          if (b == 8'hE0 || b == 8'hF0) pending.push_back(b);
          else if (!ignored(b)) model_event(b, 0, 0);
        end else if (pending[pending.size()-1] == 8'hE0) begin
          if (b == 8'hF0) pending.push_back(b);
          else if (b == 8'hE0) m_err = 1;
          else begin pending.delete(); model_event(b, 1, 0); end
        end else begin
          bit e;
          e = pending[0] == 8'hE0;
          pending.delete();
          if (b == 8'hE0 || b == 8'hF0) m_err = 1;
          else model_event(b, e, 1);
        end
      end
      age = (bus.ps2_data_en_i || to || !had) ? 0 : age + 1;
    end
  end

  // Every-cycle compare of the full output bundle.
  always @(negedge clk) begin
    logic [18:0] act, exp;
    act = {bus.key_vld_o, bus.key_code_o, bus.key_ext_o, bus.key_brk_o, bus.note_vld_o,
           bus.note_idx_o, bus.note_on_o, bus.vol_up_o, bus.vol_dn_o, bus.err_o};
    exp = {m_kvld, m_code, m_ext, m_brk, m_nvld, m_idx, m_on, m_up, m_dn, m_err};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL outputs @%0t: got %h expected %h", $time, act, exp);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drives one strobe; returns #1 after the sampling edge, when the event outputs are visible.
  task automatic send(input logic [7:0] b);
    bus.ps2_data_i = b;
    bus.ps2_data_en_i = 1'b1;
    @(posedge clk); #1;
    bus.ps2_data_en_i = 1'b0;
    bus.ps2_data_i = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n;
    bus.ps2_data_i = 8'h00;
    bus.ps2_data_en_i = 1'b0;
    idle(3);
    check("rst_code", bus.key_code_o, 0);
    check("rst_note_on", bus.note_on_o, 0);
    rst_n = 1'b1;
    idle(2);

    send(8'h1C);
    check("mk_kvld", bus.key_vld_o, 1);
    check("mk_nvld", bus.note_vld_o, 1);
    check("mk_idx", bus.note_idx_o, 0);
    check("mk_on", bus.note_on_o, 1);
    idle(3);
    send(8'hF0); idle(2);
    send(8'h1C);
    check("brk_kvld", bus.key_vld_o, 1);
    check("brk_flag", bus.key_brk_o, 1);
    check("brk_on", bus.note_on_o, 0);
    idle(3);

    send(8'h1C); idle(1);
    send(8'h1C);
    check("rep_kvld", bus.key_vld_o, 1);
    check("rep_nvld", bus.note_vld_o, 0);
    send(8'h1C);
    check("rep_on", bus.note_on_o, 1);
    idle(2);

    send(8'h23);
    check("n2_idx", bus.note_idx_o, 2);
    send(8'hF0); send(8'h1C);
    check("n2_other_brk_on", bus.note_on_o, 1);
    idle(2);
    send(8'hF0); send(8'h23);
    check("n2_brk_on", bus.note_on_o, 0);
    check("n2_brk_idx", bus.note_idx_o, 2);
    idle(2);

    send(8'hAA);
    check("discard_kvld", bus.key_vld_o, 0);
    send(8'h7B);
    check("vol_dn", bus.vol_dn_o, 1);
    send(8'h76);
    check("other_code", bus.key_code_o, 8'h76);
    idle(2);

    send(8'hE0); idle(2); send(8'hF0); idle(2);
    send(8'h75);
    check("eb_ext", bus.key_ext_o, 1);
    check("eb_brk", bus.key_brk_o, 1);
    check("eb_nvld", bus.note_vld_o, 0);
    idle(2);
    send(8'hE0); send(8'h75);
    check("e_code", bus.key_code_o, 8'h75);
    check("e_ext", bus.key_ext_o, 1);
    check("e_brk", bus.key_brk_o, 0);
    idle(2);

    send(8'hE0); send(8'hE0);
    check("ee_err", bus.err_o, 1);
    send(8'h1C);
    check("ee_ext", bus.key_ext_o, 1);
    check("ee_ext_nvld", bus.note_vld_o, 0);
    send(8'hF0); send(8'hF0);
    check("ff_err", bus.err_o, 1);
    idle(2);

    send(8'hF0); idle(1);
    #2 rst_n = 1'b0;
    idle(2);
    #2 rst_n = 1'b1;
    idle(1);
    send(8'h1C);
    check("rst_mk_kvld", bus.key_vld_o, 1);
    check("rst_mk_brk", bus.key_brk_o, 0);
    check("rst_mk_on", bus.note_on_o, 1);
    idle(2);

    send(8'hE0);
    n = 0;
    while (!bus.err_o && n < TO + 1000) begin @(posedge clk); #1; n++; end
    check("timeout_cycles", n, TO);
    idle(2);
    send(8'h79);
    check("to_vol_up", bus.vol_up_o, 1);
    check("to_ext", bus.key_ext_o, 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
